// File: rtl/uniboard_pkg.sv
// Definitions shared by the uniboard command receiver and reply framer:
// framing characters, reply-framer state encoding and a byte-select helper.
package uniboard_pkg;

    localparam logic [7:0] START_CHAR = 8'h01;
    localparam logic [7:0] ESC_CHAR   = 8'h1B;
    localparam logic [7:0] END_CHAR   = 8'h17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PADDR,
        ST_RADDR,
        ST_DATA,
        ST_ESC,
        ST_END
    } frame_state_t;

    // Byte idx of a 32-bit register word, LSB first; out-of-range reads as zero.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input int unsigned idx);
        if (idx < 4)
            return word[idx*8 +: 8];
        return 8'h00;
    endfunction

endpackage

// File: rtl/reply_escape_check.sv
// Flags bytes that collide with a framing character and must be preceded
// by ESC_CHAR when sent as header or payload.
module reply_escape_check
    import uniboard_pkg::*;
(
    input  logic [7:0] value,
    output logic       needs_escape
);

    assign needs_escape = (value == START_CHAR) || (value == ESC_CHAR) || (value == END_CHAR);

endmodule

// File: rtl/reply_framer.sv
// Serialises one register-read reply (start, peripheral, register, data bytes,
// end) onto a valid/ready byte stream, escaping in-band framing characters.
module reply_framer
    import uniboard_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk_12MHz,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  periph_addr,
    input  logic [7:0]  reg_addr,
    input  logic [2:0]  reg_size,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(MAX_BYTES) + 1;

    frame_state_t  state, state_next;
    frame_state_t  resume, resume_next;
    logic [7:0]    periph_q, reg_q;
    logic [31:0]   data_q;
    logic [CW-1:0] size_q, idx, idx_next, idx_inc;
    logic          done_q;

    // Candidate for the byte that follows the current one; it is screened
    // for escaping before the state register commits to it.
    frame_state_t  cand_state;
    logic [7:0]    cand_byte;
    logic          cand_check, cand_escape;
    logic          accept, fire;

    assign accept  = (state == ST_IDLE) && start;
    assign fire    = tx_valid && tx_ready;
    assign idx_inc = idx + CW'(1);

    reply_escape_check u_escape_check (
        .value        (cand_byte),
        .needs_escape (cand_escape)
    );

    // NOTE: every register here resets asynchronously and updates with
    // non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            resume   <= ST_IDLE;
            idx      <= '0;
            done_q   <= 1'b0;
            periph_q <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            size_q   <= '0;
        end else begin
            state  <= state_next;
            resume <= resume_next;
            idx    <= idx_next;
            done_q <= (state == ST_END) && tx_ready;
            if (accept) begin
                periph_q <= periph_addr;
                reg_q    <= reg_addr;
                data_q   <= data;
                size_q   <= ({29'b0, reg_size} > 32'(MAX_BYTES)) ? CW'(MAX_BYTES) : CW'(reg_size);
            end
        end
    end

    // NOTE: all outputs of this block get a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next  = state;
        resume_next = resume;
        idx_next    = idx;
        cand_state  = ST_IDLE;
        cand_byte   = 8'h00;
        cand_check  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_START;
            end
            ST_START: begin
                cand_state = ST_PADDR;
                cand_byte  = periph_q;
                cand_check = 1'b1;
            end
            ST_PADDR: begin
                cand_state = ST_RADDR;
                cand_byte  = reg_q;
                cand_check = 1'b1;
            end
            ST_RADDR: begin
                if (size_q == '0) begin
                    cand_state = ST_END;
                end else begin
                    cand_state = ST_DATA;
                    cand_byte  = byte_of(data_q, 0);
                    cand_check = 1'b1;
                end
            end
            ST_DATA: begin
                if (idx_inc == size_q) begin
                    cand_state = ST_END;
                end else begin
                    cand_state = ST_DATA;
                    cand_byte  = byte_of(data_q, 32'(idx_inc));
                    cand_check = 1'b1;
                end
            end
            ST_ESC:  cand_state = resume;
            ST_END:  cand_state = ST_IDLE;
            default: cand_state = ST_IDLE;
        endcase

        if (fire) begin
            if (cand_check && cand_escape) begin
                state_next  = ST_ESC;
                resume_next = cand_state;
            end else begin
                state_next  = cand_state;
            end
            // idx always names the data byte that is shown or pending behind an ESC.
            if (state == ST_RADDR)
                idx_next = '0;
            else if (state == ST_DATA)
                idx_next = idx_inc;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state)
            ST_IDLE:  tx_data = 8'h00;
            ST_START: tx_data = START_CHAR;
            ST_PADDR: tx_data = periph_q;
            ST_RADDR: tx_data = reg_q;
            ST_DATA:  tx_data = byte_of(data_q, 32'(idx));
            ST_ESC:   tx_data = ESC_CHAR;
            ST_END:   tx_data = END_CHAR;
            default:  tx_data = 8'h00;
        endcase
    end

    assign tx_valid = (state != ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_reply_framer.sv
// Directed bench for reply_framer: frame contents, escaping, stalls,
// start handling around busy/done, and mid-frame reset.
module tb_reply_framer;

    logic        clk_12MHz = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  periph_addr;
    logic [7:0]  reg_addr;
    logic [2:0]  reg_size;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int compares   = 0;
    int mismatches = 0;

    logic [7:0] exp_q[$];

    reply_framer #(.MAX_BYTES(4)) dut (
        .clk_12MHz   (clk_12MHz),
        .reset_n     (reset_n),
        .start       (start),
        .periph_addr (periph_addr),
        .reg_addr    (reg_addr),
        .reg_size    (reg_size),
        .data        (data),
        .busy        (busy),
        .done        (done),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise start for one cycle from a falling edge; returns on the falling
    // edge after acceptance, where the start byte should be on the bus.
    task automatic pulse_start(input logic [7:0] pa, input logic [7:0] ra,
                               input logic [2:0] sz, input logic [31:0] d);
        periph_addr = pa;
        reg_addr    = ra;
        reg_size    = sz;
        data        = d;
        start       = 1'b1;
        @(negedge clk_12MHz);
        start       = 1'b0;
    endtask

    // Collect one frame against exp_q; rnd randomises tx_ready, mid_start
    // (cycle index, or -1) pulses a start that must be ignored. Returns on
    // the falling edge of the done cycle.
    task automatic run_frame(input bit rnd, input int mid_start);
        int         k = 0;
        int         cycles = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        bit         r;
        while (k < exp_q.size() && cycles < 200) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = r;
            if (cycles == mid_start) begin
                start       = 1'b1;
                periph_addr = 8'hAA;
                reg_size    = 3'd3;
            end else begin
                start = 1'b0;
            end
            check("busy_in_frame", busy, 1'b1);
            if (!rnd)
                check("no_bubble", tx_valid, 1'b1);
            if (prev_stall)
                check("stall_stable", tx_data, prev_data);
            if (tx_valid && r) begin
                check($sformatf("byte%0d", k), tx_data, exp_q[k]);
                k++;
            end
            prev_stall = tx_valid && !r;
            prev_data  = tx_data;
            @(negedge clk_12MHz);
            cycles++;
        end
        start = 1'b0;
        check("frame_complete", k, exp_q.size());
        check("done_pulse", done, 1'b1);
        check("busy_after_end", busy, 1'b0);
        check("valid_after_end", tx_valid, 1'b0);
        tx_ready = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk_12MHz);
        check("done_single", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        periph_addr = 8'h00;
        reg_addr    = 8'h00;
        reg_size    = 3'd0;
        data        = 32'h0;
        tx_ready    = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_data", tx_data, 8'h00);
        reset_n = 1'b1;
        @(negedge clk_12MHz);
        check("post_rst_idle", tx_valid, 1'b0);

        // Plain two-byte reply, tx_ready held high.
        exp_q = '{8'h01, 8'h02, 8'h05, 8'hEF, 8'hBE, 8'h17};
        pulse_start(8'h02, 8'h05, 3'd2, 32'h0000BEEF);
        run_frame(1'b0, -1);
        idle_cycle();

        // Every header and data byte is a framing character.
        exp_q = '{8'h01, 8'h1B, 8'h17, 8'h1B, 8'h1B, 8'h1B, 8'h01, 8'h17};
        pulse_start(8'h17, 8'h1B, 3'd1, 32'h00000001);
        run_frame(1'b0, -1);
        idle_cycle();

        // Zero-length payload goes straight to the end byte.
        exp_q = '{8'h01, 8'h03, 8'h00, 8'h17};
        pulse_start(8'h03, 8'h00, 3'd0, 32'hFFFFFFFF);
        run_frame(1'b0, -1);
        idle_cycle();

        // Oversized request clamps to 4 bytes; random back-pressure.
        tx_ready = 1'b0;
        exp_q = '{8'h01, 8'h10, 8'h20, 8'h44, 8'h33, 8'h22, 8'h11, 8'h17};
        pulse_start(8'h10, 8'h20, 3'd7, 32'h11223344);
        run_frame(1'b1, -1);
        idle_cycle();

        // Start while busy is ignored; start in the done cycle is taken.
        exp_q = '{8'h01, 8'h02, 8'h05, 8'hEF, 8'hBE, 8'h17};
        pulse_start(8'h02, 8'h05, 3'd2, 32'h0000BEEF);
        run_frame(1'b0, 2);
        exp_q = '{8'h01, 8'h03, 8'h00, 8'h17};
        pulse_start(8'h03, 8'h00, 3'd0, 32'h0);
        run_frame(1'b0, -1);
        idle_cycle();

        // Reset mid-frame after three bytes have gone out.
        pulse_start(8'h02, 8'h05, 3'd2, 32'h0000BEEF);
        tx_ready = 1'b1;
        check("rf_b0", tx_data, 8'h01);
        @(negedge clk_12MHz);
        check("rf_b1", tx_data, 8'h02);
        @(negedge clk_12MHz);
        check("rf_b2", tx_data, 8'h05);
        @(negedge clk_12MHz);
        check("rf_b3_shown", tx_data, 8'hEF);
        reset_n = 1'b0;
        #1;
        check("rf_valid_now", tx_valid, 1'b0);
        check("rf_busy_now", busy, 1'b0);
        check("rf_data_now", tx_data, 8'h00);
        repeat (3) begin
            @(negedge clk_12MHz);
            check("rf_held_valid", tx_valid, 1'b0);
            check("rf_held_done", done, 1'b0);
        end
        reset_n  = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk_12MHz);
        check("rf_no_end_byte", tx_valid, 1'b0);
        exp_q = '{8'h01, 8'h03, 8'h00, 8'h17};
        pulse_start(8'h03, 8'h00, 3'd0, 32'h0);
        run_frame(1'b0, -1);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule

// File: doc/reply_framer.md
REPLY_FRAMER -- requirements
Module: reply_framer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, meaning the maximum number of register data bytes per reply.
REQ-002 SHALL have port clk_12MHz  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to frame one reply.
REQ-005 SHALL have port periph_addr  input  8  peripheral address echoed in the reply header.
REQ-006 SHALL have port reg_addr  input  8  register address echoed in the reply header.
REQ-007 SHALL have port reg_size  input  3  number of data bytes to send.
REQ-008 SHALL have port data  input  32  register contents; byte 0 = data[7:0].
REQ-009 SHALL have port busy  output  1  high from start acceptance until the end byte is accepted.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the end byte is accepted.
REQ-011 SHALL have port tx_data  output  8  byte offered to the UART transmitter.
REQ-012 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-013 SHALL have port tx_ready  input  1  transmitter can take a byte; transfer occurs when tx_valid and tx_ready are both high.

Function
REQ-014 SHALL accept start only when busy is low, latching periph_addr, reg_addr, reg_size and data; start while busy is ignored.
REQ-015 SHALL clamp a latched reg_size greater than MAX_BYTES to MAX_BYTES.
REQ-016 SHALL emit the frame 0x01, periph_addr, reg_addr, data bytes 0..reg_size-1 (LSB first), 0x17.
REQ-017 SHALL precede any header or data byte equal to 0x01, 0x1B or 0x17 with escape byte 0x1B; the start and end bytes are never escaped.
REQ-018 SHALL use states IDLE -> START -> PADDR -> RADDR -> DATA (repeated per byte) -> END -> IDLE, with sub-state ESC inserted before any escaped byte.
REQ-019 SHALL skip DATA entirely when reg_size is 0 (RADDR -> END).
REQ-020 SHALL assert tx_valid with 0x01 on the cycle after start is accepted.
REQ-021 SHALL hold tx_data stable and tx_valid high until the transfer occurs, and advance exactly one byte per transfer.
REQ-022 SHALL, when tx_ready is held high, present a new byte on every cycle (no bubbles, including across escapes).
REQ-023 SHALL deassert busy and pulse done in the cycle after the 0x17 transfer; a start in that same cycle is accepted.
REQ-024 SHALL keep the data byte index in a counter of width clog2(MAX_BYTES)+1, with no wrap-around.

Reset
REQ-025 SHALL, on reset_n low (asynchronous, including mid-frame), force state to IDLE, busy=0, done=0, tx_valid=0, tx_data=0x00, and clear the latched fields; the partial frame is abandoned without an end byte.
REQ-026 SHALL resume operation on the first rising edge of clk_12MHz after reset_n goes high.

Structure
REQ-027 SHALL take the constants START_CHAR=0x01, ESC_CHAR=0x1B and END_CHAR=0x17, plus the state enum typedef, from the shared package uniboard_pkg, which the command receiver also uses.
REQ-028 SHALL place the special-character test in a sub-module reply_escape_check (8-bit in, 1-bit needs_escape out, combinational).

Verification
REQ-029 SHALL test this case: periph 0x02, reg 0x05, size 2, data 0x0000BEEF, tx_ready always 1 -> 01 02 05 EF BE 17 on consecutive cycles; done pulses once.
REQ-030 SHALL test this case: periph 0x17, reg 0x1B, size 1, data 0x01 -> 01 1B 17 1B 1B 1B 01 17.
REQ-031 SHALL test this case: size 0, periph 0x03, reg 0x00 -> 01 03 00 17.
REQ-032 SHALL test this case: size 7, data 0x11223344, with tx_ready toggling randomly -> 01 pa ra 44 33 22 11 17, and tx_data stays stable while it is stalled.
REQ-033 SHALL test this case: a second start pulsed mid-frame -> ignored; a start in the done cycle -> its 0x01 follows on the next cycle.
REQ-034 SHALL test this case: reset_n pulsed low after the third byte -> tx_valid=0 and busy=0 immediately, no 0x17 is sent, and the next start produces a complete frame.
